// File: rtl/ysyx_25040129_axi_if.sv
// AXI4-Lite bundle with all five channels; "master" drives requests, "slave" drives responses.
interface ysyx_25040129_axi_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_25040129_axi_arbiter.sv
// Round-robin AXI4-Lite arbiter: IFU (read-only) and LSU (read/write) share one slave,
// one whole transaction per grant, with an IDLE cycle between grants.
module ysyx_25040129_axi_arbiter (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_25040129_axi_if.slave         ifu,
  ysyx_25040129_axi_if.slave         lsu,
  ysyx_25040129_axi_if.master        s
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t state, state_next;
  logic   prio_lsu, prio_next;
  logic   req_i, req_lr, req_lw, req_l;

  assign req_i  = ifu.arvalid;
  assign req_lr = lsu.arvalid;
  assign req_lw = lsu.awvalid | lsu.wvalid;
  assign req_l  = req_lr | req_lw;

  // NOTE: reset is synchronous, so rst only takes effect on a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio_lsu <= 1'b0;
    end else begin
      state    <= state_next;
      prio_lsu <= prio_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_next  = state;
    prio_next   = prio_lsu;

    ifu.arready = 1'b0;
    ifu.rvalid  = 1'b0;
    ifu.rdata   = s.rdata;
    ifu.rresp   = s.rresp;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bvalid  = 1'b0;
    ifu.bresp   = 2'b00;

    lsu.arready = 1'b0;
    lsu.rvalid  = 1'b0;
    lsu.rdata   = s.rdata;
    lsu.rresp   = s.rresp;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bvalid  = 1'b0;
    lsu.bresp   = s.bresp;

    s.araddr    = 32'h0;
    s.arvalid   = 1'b0;
    s.rready    = 1'b0;
    s.awaddr    = 32'h0;
    s.awvalid   = 1'b0;
    s.wdata     = 32'h0;
    s.wstrb     = 4'h0;
    s.wvalid    = 1'b0;
    s.bready    = 1'b0;

    unique case (state)
      IDLE: begin
        // LSU wins if it is alone or holds the pointer; its read beats its write.
        if (req_l && (!req_i || prio_lsu)) begin
          state_next = req_lr ? LSU_RD : LSU_WR;
          prio_next  = 1'b0;
        end else if (req_i) begin
          state_next = IFU_RD;
          prio_next  = 1'b1;
        end
      end
      IFU_RD: begin
        s.araddr    = ifu.araddr;
        s.arvalid   = ifu.arvalid;
        ifu.arready = s.arready;
        ifu.rvalid  = s.rvalid;
        s.rready    = ifu.rready;
        if (s.rvalid && ifu.rready) state_next = IDLE;
      end
      LSU_RD: begin
        s.araddr    = lsu.araddr;
        s.arvalid   = lsu.arvalid;
        lsu.arready = s.arready;
        lsu.rvalid  = s.rvalid;
        s.rready    = lsu.rready;
        if (s.rvalid && lsu.rready) state_next = IDLE;
      end
      LSU_WR: begin
        // AW and W are independent pass-throughs; only B closes the transaction.
        s.awaddr    = lsu.awaddr;
        s.awvalid   = lsu.awvalid;
        lsu.awready = s.awready;
        s.wdata     = lsu.wdata;
        s.wstrb     = lsu.wstrb;
        s.wvalid    = lsu.wvalid;
        lsu.wready  = s.wready;
        lsu.bvalid  = s.bvalid;
        s.bready    = lsu.bready;
        if (s.bvalid && lsu.bready) state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040129_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI4-Lite arbiter; slave responses are driven by hand.
module tb_ysyx_25040129_axi_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   aw_hs = 0;
  int   w_hs = 0;

  ysyx_25040129_axi_if ifu_bus ();
  ysyx_25040129_axi_if lsu_bus ();
  ysyx_25040129_axi_if s_bus ();

  ysyx_25040129_axi_arbiter dut (
    .clk (clk),
    .rst (rst),
    .ifu (ifu_bus),
    .lsu (lsu_bus),
    .s   (s_bus)
  );

  always #5 clk = ~clk;

  // Slave-side handshake counters for the write channels.
  always @(posedge clk) begin
    if (s_bus.awvalid && s_bus.awready) aw_hs <= aw_hs + 1;
    if (s_bus.wvalid && s_bus.wready)   w_hs  <= w_hs + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] vr_outs();
    return {ifu_bus.arready, ifu_bus.rvalid, ifu_bus.awready, ifu_bus.wready, ifu_bus.bvalid,
            lsu_bus.arready, lsu_bus.rvalid, lsu_bus.awready, lsu_bus.wready, lsu_bus.bvalid,
            s_bus.arvalid, s_bus.rready, s_bus.awvalid, s_bus.wvalid, s_bus.bready};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    lsu_bus.arvalid = 1'b1;
    tick(); tick();
    #1;
    vectors++;
    if (dut.state !== 2'd0) begin
      miscompares++; $display("FAIL reset_state: got %0d expected 0", dut.state);
    end
    vectors++;
    if (dut.prio_lsu !== 1'b0) begin
      miscompares++; $display("FAIL reset_prio: got %b expected 0", dut.prio_lsu);
    end
    vectors++;
    if (vr_outs() !== 15'h0) begin
      miscompares++; $display("FAIL reset_outs: got %h expected 0000", vr_outs());
    end
    lsu_bus.arvalid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ifu_read();
    ifu_bus.araddr = 32'h8000_0000; ifu_bus.arvalid = 1'b1;
    #1;
    vectors++;
    if (s_bus.arvalid !== 1'b0) begin
      miscompares++; $display("FAIL ifu_pre_grant: s_arvalid got %b expected 0", s_bus.arvalid);
    end
    tick();
    vectors++;
    if ({s_bus.arvalid, ifu_bus.arready, lsu_bus.arready, s_bus.araddr} !== {3'b110, 32'h8000_0000}) begin
      miscompares++;
      $display("FAIL ifu_grant: got arv=%b ifu_rdy=%b lsu_rdy=%b addr=%h expected 1 1 0 80000000",
               s_bus.arvalid, ifu_bus.arready, lsu_bus.arready, s_bus.araddr);
    end
    tick();
    ifu_bus.arvalid = 1'b0;
    #1;
    vectors++;
    if ({ifu_bus.rvalid, dut.state} !== {1'b0, 2'd1}) begin
      miscompares++; $display("FAIL ifu_wait: rvalid=%b state=%0d expected 0 1", ifu_bus.rvalid, dut.state);
    end
    tick();
    s_bus.rvalid = 1'b1; s_bus.rdata = 32'h0000_0413; s_bus.rresp = 2'b00;
    #1;
    vectors++;
    if ({ifu_bus.rvalid, ifu_bus.rdata, s_bus.rready} !== {1'b1, 32'h0000_0413, 1'b1}) begin
      miscompares++;
      $display("FAIL ifu_rdata: rvalid=%b rdata=%h rready=%b expected 1 00000413 1",
               ifu_bus.rvalid, ifu_bus.rdata, s_bus.rready);
    end
    vectors++;
    if ({lsu_bus.arready, lsu_bus.rvalid, lsu_bus.awready, lsu_bus.wready, lsu_bus.bvalid} !== 5'b0) begin
      miscompares++; $display("FAIL ifu_lsu_quiet: lsu valid/ready nonzero");
    end
    tick();
    s_bus.rvalid = 1'b0;
    #1;
    vectors++;
    if ({dut.state, dut.prio_lsu} !== {2'd0, 1'b1}) begin
      miscompares++; $display("FAIL ifu_done: state=%0d prio=%b expected 0 1", dut.state, dut.prio_lsu);
    end
  endtask

  task automatic test_conflict();
    rst = 1'b1; tick(); rst = 1'b0;
    ifu_bus.araddr = 32'h8000_0100; ifu_bus.arvalid = 1'b1;
    lsu_bus.araddr = 32'h8000_0200; lsu_bus.arvalid = 1'b1;
    tick();
    vectors++;
    if ({dut.state, ifu_bus.arready, lsu_bus.arready, s_bus.araddr} !== {2'd1, 2'b10, 32'h8000_0100}) begin
      miscompares++;
      $display("FAIL conflict1_ifu_first: state=%0d rdy=%b%b addr=%h expected 1 10 80000100",
               dut.state, ifu_bus.arready, lsu_bus.arready, s_bus.araddr);
    end
    tick();
    ifu_bus.arvalid = 1'b0; s_bus.rvalid = 1'b1; s_bus.rdata = 32'h1111_1111;
    #1;
    vectors++;
    if ({ifu_bus.rvalid, lsu_bus.rvalid, ifu_bus.rdata} !== {2'b10, 32'h1111_1111}) begin
      miscompares++;
      $display("FAIL conflict1_ifu_data: rvalid=%b%b rdata=%h expected 10 11111111",
               ifu_bus.rvalid, lsu_bus.rvalid, ifu_bus.rdata);
    end
    tick();
    s_bus.rvalid = 1'b0;
    ifu_bus.araddr = 32'h8000_0104; ifu_bus.arvalid = 1'b1;
    #1;
    vectors++;
    if ({dut.state, ifu_bus.arready, lsu_bus.arready, s_bus.arvalid} !== {2'd0, 3'b000}) begin
      miscompares++;
      $display("FAIL conflict_turnaround: state=%0d rdy=%b%b arvalid=%b expected 0 00 0",
               dut.state, ifu_bus.arready, lsu_bus.arready, s_bus.arvalid);
    end
    tick();
    vectors++;
    if ({dut.state, ifu_bus.arready, lsu_bus.arready, s_bus.araddr} !== {2'd2, 2'b01, 32'h8000_0200}) begin
      miscompares++;
      $display("FAIL conflict2_lsu_first: state=%0d rdy=%b%b addr=%h expected 2 01 80000200",
               dut.state, ifu_bus.arready, lsu_bus.arready, s_bus.araddr);
    end
    tick();
    lsu_bus.arvalid = 1'b0; s_bus.rvalid = 1'b1; s_bus.rdata = 32'h2222_2222;
    #1;
    vectors++;
    if ({lsu_bus.rvalid, ifu_bus.rvalid, lsu_bus.rdata} !== {2'b10, 32'h2222_2222}) begin
      miscompares++;
      $display("FAIL conflict2_lsu_data: rvalid=%b%b rdata=%h expected 10 22222222",
               lsu_bus.rvalid, ifu_bus.rvalid, lsu_bus.rdata);
    end
    tick();
    s_bus.rvalid = 1'b0;
    tick();
    vectors++;
    if ({dut.state, s_bus.araddr} !== {2'd1, 32'h8000_0104}) begin
      miscompares++; $display("FAIL conflict2_ifu_after: state=%0d addr=%h expected 1 80000104", dut.state, s_bus.araddr);
    end
    tick();
    ifu_bus.arvalid = 1'b0; s_bus.rvalid = 1'b1;
    tick();
    s_bus.rvalid = 1'b0;
  endtask

  task automatic test_lsu_write();
    lsu_bus.awaddr = 32'ha000_03f8; lsu_bus.awvalid = 1'b1;
    lsu_bus.wdata = 32'h0000_0041; lsu_bus.wstrb = 4'b0001; lsu_bus.wvalid = 1'b1;
    tick();
    vectors++;
    if ({dut.state, s_bus.awvalid, s_bus.wvalid, s_bus.awaddr, s_bus.wdata, s_bus.wstrb}
        !== {2'd3, 2'b11, 32'ha000_03f8, 32'h0000_0041, 4'b0001}) begin
      miscompares++;
      $display("FAIL wr_grant: state=%0d awv=%b wv=%b awaddr=%h wdata=%h wstrb=%b",
               dut.state, s_bus.awvalid, s_bus.wvalid, s_bus.awaddr, s_bus.wdata, s_bus.wstrb);
    end
    s_bus.awready = 1'b1;
    #1;
    vectors++;
    if ({lsu_bus.awready, lsu_bus.wready} !== 2'b10) begin
      miscompares++; $display("FAIL wr_aw_only: rdy=%b%b expected 10", lsu_bus.awready, lsu_bus.wready);
    end
    tick();
    lsu_bus.awvalid = 1'b0; s_bus.awready = 1'b0;
    ifu_bus.araddr = 32'h8000_0200; ifu_bus.arvalid = 1'b1;
    #1;
    vectors++;
    if ({s_bus.awvalid, ifu_bus.arready, s_bus.arvalid, s_bus.araddr} !== {3'b000, 32'h0}) begin
      miscompares++;
      $display("FAIL wr_ifu_held: awv=%b ifu_rdy=%b arv=%b araddr=%h expected 0 0 0 0",
               s_bus.awvalid, ifu_bus.arready, s_bus.arvalid, s_bus.araddr);
    end
    tick();
    s_bus.wready = 1'b1;
    #1;
    vectors++;
    if ({lsu_bus.wready, s_bus.wvalid} !== 2'b11) begin
      miscompares++; $display("FAIL wr_w: wready=%b wvalid=%b expected 1 1", lsu_bus.wready, s_bus.wvalid);
    end
    tick();
    lsu_bus.wvalid = 1'b0; s_bus.wready = 1'b0;
    s_bus.bvalid = 1'b1; s_bus.bresp = 2'b00;
    #1;
    vectors++;
    if ({lsu_bus.bvalid, lsu_bus.bresp, s_bus.bready, dut.state, ifu_bus.arready} !== {1'b1, 2'b00, 1'b1, 2'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL wr_b: bvalid=%b bresp=%b bready=%b state=%0d ifu_rdy=%b expected 1 00 1 3 0",
               lsu_bus.bvalid, lsu_bus.bresp, s_bus.bready, dut.state, ifu_bus.arready);
    end
    tick();
    s_bus.bvalid = 1'b0;
    #1;
    vectors++;
    if ({aw_hs, w_hs} !== {32'd1, 32'd1}) begin
      miscompares++; $display("FAIL wr_handshakes: aw=%0d w=%0d expected 1 1", aw_hs, w_hs);
    end
    vectors++;
    if ({dut.state, ifu_bus.arready} !== {2'd0, 1'b0}) begin
      miscompares++; $display("FAIL wr_done: state=%0d ifu_rdy=%b expected 0 0", dut.state, ifu_bus.arready);
    end
    tick();
    vectors++;
    if ({dut.state, s_bus.araddr} !== {2'd1, 32'h8000_0200}) begin
      miscompares++; $display("FAIL wr_ifu_after: state=%0d addr=%h expected 1 80000200", dut.state, s_bus.araddr);
    end
    tick();
    ifu_bus.arvalid = 1'b0; s_bus.rvalid = 1'b1;
    tick();
    s_bus.rvalid = 1'b0;
  endtask

  task automatic test_rresp_error();
    lsu_bus.araddr = 32'h0000_1000; lsu_bus.arvalid = 1'b1;
    tick();
    tick();
    lsu_bus.arvalid = 1'b0;
    s_bus.rvalid = 1'b1; s_bus.rresp = 2'b10; s_bus.rdata = 32'hdead_beef;
    #1;
    vectors++;
    if ({lsu_bus.rvalid, lsu_bus.rresp, lsu_bus.rdata} !== {1'b1, 2'b10, 32'hdead_beef}) begin
      miscompares++;
      $display("FAIL rresp_fwd: rvalid=%b rresp=%b rdata=%h expected 1 10 deadbeef",
               lsu_bus.rvalid, lsu_bus.rresp, lsu_bus.rdata);
    end
    tick();
    s_bus.rvalid = 1'b0; s_bus.rresp = 2'b00;
    tick();
    vectors++;
    if ({dut.state, s_bus.arvalid} !== {2'd0, 1'b0}) begin
      miscompares++; $display("FAIL rresp_no_retry: state=%0d arvalid=%b expected 0 0", dut.state, s_bus.arvalid);
    end
  endtask

  task automatic test_reset_mid();
    ifu_bus.arvalid = 1'b1; ifu_bus.araddr = 32'h8000_0300;
    tick();
    tick();
    ifu_bus.arvalid = 1'b0; s_bus.rvalid = 1'b1;
    tick();
    s_bus.rvalid = 1'b0;
    lsu_bus.araddr = 32'h0000_2000; lsu_bus.arvalid = 1'b1;
    tick();
    vectors++;
    if (dut.state !== 2'd2) begin
      miscompares++; $display("FAIL mid_lsu_grant: state=%0d expected 2", dut.state);
    end
    tick();
    lsu_bus.arvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({dut.state, dut.prio_lsu, vr_outs()} !== {2'd0, 1'b0, 15'h0}) begin
      miscompares++;
      $display("FAIL mid_reset: state=%0d prio=%b outs=%h expected 0 0 0000", dut.state, dut.prio_lsu, vr_outs());
    end
    ifu_bus.araddr = 32'h8000_0000; ifu_bus.arvalid = 1'b1;
    tick();
    vectors++;
    if ({dut.state, s_bus.araddr, s_bus.arvalid} !== {2'd1, 32'h8000_0000, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_fresh_grant: state=%0d addr=%h arv=%b expected 1 80000000 1",
               dut.state, s_bus.araddr, s_bus.arvalid);
    end
    tick();
    ifu_bus.arvalid = 1'b0;
    s_bus.rvalid = 1'b1; s_bus.rdata = 32'h0000_0413;
    #1;
    vectors++;
    if ({ifu_bus.rvalid, ifu_bus.rdata} !== {1'b1, 32'h0000_0413}) begin
      miscompares++; $display("FAIL mid_fresh_data: rvalid=%b rdata=%h expected 1 00000413", ifu_bus.rvalid, ifu_bus.rdata);
    end
    tick();
    s_bus.rvalid = 1'b0;
    #1;
    vectors++;
    if (dut.state !== 2'd0) begin
      miscompares++; $display("FAIL mid_fresh_done: state=%0d expected 0", dut.state);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifu_bus.araddr = '0; ifu_bus.arvalid = 1'b0; ifu_bus.rready = 1'b1;
    ifu_bus.awaddr = '0; ifu_bus.awvalid = 1'b0; ifu_bus.wdata = '0;
    ifu_bus.wstrb = '0; ifu_bus.wvalid = 1'b0; ifu_bus.bready = 1'b0;
    lsu_bus.araddr = '0; lsu_bus.arvalid = 1'b0; lsu_bus.rready = 1'b1;
    lsu_bus.awaddr = '0; lsu_bus.awvalid = 1'b0; lsu_bus.wdata = '0;
    lsu_bus.wstrb = '0; lsu_bus.wvalid = 1'b0; lsu_bus.bready = 1'b1;
    s_bus.arready = 1'b1; s_bus.rdata = '0; s_bus.rresp = '0; s_bus.rvalid = 1'b0;
    s_bus.awready = 1'b0; s_bus.wready = 1'b0; s_bus.bresp = '0; s_bus.bvalid = 1'b0;

    test_reset();
    test_ifu_read();
    test_conflict();
    test_lsu_write();
    test_rresp_error();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
